// File: rtl/seven_seg_scan_n.sv
// seven_seg_scan_n
//   Multiplexed N-digit seven-segment driver with hex decode, per-digit
//   decimal points and blanking, leading-zero suppression and PWM brightness.
//   All display inputs are captured into shadow registers once per frame so a
//   frame never mixes old and new values.
//
// Ports
//   cu_clk          system clock
//   reset           asynchronous active-high reset
//   digits          4*DIGITS bits, nibble i -> digit i (digit 0 rightmost)
//   dp              decimal point enable per digit
//   blank           force digit dark (dp included)
//   lz_suppress     enable leading-zero suppression
//   brightness      lit slots per digit dwell, 0 = off
//   frame_tick      one-cycle pulse following each shadow load
//   io_7seg_select  digit enables (at most one active)
//   io_7seg         bit0..6 = segments a..g, bit7 = dp
module seven_seg_scan_n #(
    parameter int DIGITS      = 4,
    parameter int SLOT_CYCLES = 6250,
    parameter int BRIGHT_W    = 4,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  cu_clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_suppress,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic                  frame_tick,
    output logic [DIGITS-1:0]     io_7seg_select,
    output logic [7:0]            io_7seg
);

    localparam int PRE_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic              INV     = (ACTIVE_LOW != 0);
    localparam logic [7:0]        SEG_OFF = INV ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_OFF = INV ? '1 : '0;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Scan state
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [BRIGHT_W-1:0] slot_q, slot_d;
    logic [DIG_W-1:0]    dig_q, dig_d;
    logic                load_pending_q, load_pending_d;
    logic                frame_tick_q, frame_tick_d;

    // Shadow registers
    logic [4*DIGITS-1:0] sh_digits_q, sh_digits_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [DIGITS-1:0]   sh_blank_q, sh_blank_d;
    logic                sh_lz_q, sh_lz_d;
    logic [BRIGHT_W-1:0] sh_bright_q, sh_bright_d;

    // Output registers, stored in pin polarity
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   sel_q, sel_d;

    logic                load;
    logic [DIGITS-1:0]   sup;
    logic                run;
    logic                lit;
    logic [3:0]          nib;
    logic [7:0]          seg_ah;
    logic [DIGITS-1:0]   sel_ah;

    // Counters and shadow load
    always_comb begin
        pre_d          = pre_q;
        slot_d         = slot_q;
        dig_d          = dig_q;
        load_pending_d = 1'b0;
        load           = 1'b0;
        sh_digits_d    = sh_digits_q;
        sh_dp_d        = sh_dp_q;
        sh_blank_d     = sh_blank_q;
        sh_lz_d        = sh_lz_q;
        sh_bright_d    = sh_bright_q;

        if (load_pending_q) begin
            // Counters hold on the post-reset load edge so the first frame
            // starts cleanly at digit 0, slot 0 with valid shadows.
            load = 1'b1;
        end else if (pre_q == PRE_W'(SLOT_CYCLES - 1)) begin
            pre_d  = '0;
            slot_d = slot_q + 1'b1;
            if (slot_q == '1) begin
                if (dig_q == DIG_W'(DIGITS - 1)) begin
                    dig_d = '0;
                    load  = 1'b1;
                end else begin
                    dig_d = dig_q + 1'b1;
                end
            end
        end else begin
            pre_d = pre_q + 1'b1;
        end

        frame_tick_d = load;
        if (load) begin
            sh_digits_d = digits;
            sh_dp_d     = dp;
            sh_blank_d  = blank;
            sh_lz_d     = lz_suppress;
            sh_bright_d = brightness;
        end
    end

    // Lit decision and decode for the current digit
    always_comb begin
        sup = '0;
        run = 1'b1;
        // Walk from the most significant digit down; a digit is suppressed
        // while every nibble from the top down to it is zero. Digit 0 excluded.
        for (int unsigned k = 0; k + 1 < DIGITS; k++) begin
            run = run & (sh_digits_q[4*(DIGITS-1-k) +: 4] == 4'h0);
            sup[DIGITS-1-k] = sh_lz_q & run;
        end

        nib    = sh_digits_q[dig_q*4 +: 4];
        lit    = (slot_q < sh_bright_q) && !sh_blank_q[dig_q] &&
                 (!sup[dig_q] || sh_dp_q[dig_q]);
        seg_ah = '0;
        sel_ah = '0;
        if (lit) begin
            seg_ah = {sh_dp_q[dig_q], sup[dig_q] ? 7'h00 : hex7(nib)};
            sel_ah[dig_q] = 1'b1;
        end
        seg_d = INV ? ~seg_ah : seg_ah;
        sel_d = INV ? ~sel_ah : sel_ah;
    end

    always_ff @(posedge cu_clk or posedge reset) begin
        if (reset) begin
            pre_q          <= '0;
            slot_q         <= '0;
            dig_q          <= '0;
            load_pending_q <= 1'b1;
            frame_tick_q   <= 1'b0;
            sh_digits_q    <= '0;
            sh_dp_q        <= '0;
            sh_blank_q     <= '0;
            sh_lz_q        <= 1'b0;
            sh_bright_q    <= '0;
            seg_q          <= SEG_OFF;
            sel_q          <= SEL_OFF;
        end else begin
            pre_q          <= pre_d;
            slot_q         <= slot_d;
            dig_q          <= dig_d;
            load_pending_q <= load_pending_d;
            frame_tick_q   <= frame_tick_d;
            sh_digits_q    <= sh_digits_d;
            sh_dp_q        <= sh_dp_d;
            sh_blank_q     <= sh_blank_d;
            sh_lz_q        <= sh_lz_d;
            sh_bright_q    <= sh_bright_d;
            seg_q          <= seg_d;
            sel_q          <= sel_d;
        end
    end

    assign frame_tick     = frame_tick_q;
    assign io_7seg        = seg_q;
    assign io_7seg_select = sel_q;

endmodule

// File: tb/tb_seven_seg_scan_n.sv
module tb_seven_seg_scan_n;

    localparam int FRAME = 32;   // 4 digits * 4 slots * 2 cycles
    localparam int DWELL = 8;
    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic        lz = 1'b0;
    logic [1:0]  bri = '0;
    logic        frame_tick;
    logic [3:0]  sel;
    logic [7:0]  seg;

    int checks = 0;
    int failures = 0;
    logic cmp_on = 1'b0;

    seven_seg_scan_n #(
        .DIGITS(4), .SLOT_CYCLES(2), .BRIGHT_W(2), .ACTIVE_LOW(1)
    ) dut (
        .cu_clk(clk), .reset(rst), .digits(digits), .dp(dp), .blank(blank),
        .lz_suppress(lz), .brightness(bri), .frame_tick(frame_tick),
        .io_7seg_select(sel), .io_7seg(seg)
    );

    initial forever begin
        #5;
        if (run) clk = ~clk;
    end

    // Reference model: one edge counter since reset release; the frame
    // position gives digit and slot by plain division.
    int          e;
    logic [15:0] m_dig;
    logic [3:0]  m_dp, m_blank;
    logic        m_lz;
    logic [1:0]  m_bri;
    logic        exp_tick;
    logic [3:0]  exp_sel;
    logic [7:0]  exp_seg;

    function automatic logic [11:0] model_out(input int ph, input logic [15:0] dg,
                                               input logic [3:0] dpv, input logic [3:0] bv,
                                               input logic lzv, input logic [1:0] br);
        int d, s, nibv;
        logic supp;
        logic [3:0] sa;
        logic [7:0] ga;
        d    = ph / DWELL;
        s    = (ph % DWELL) / 2;
        nibv = int'((dg >> (4 * d)) & 16'hF);
        supp = lzv && (d > 0) && ((dg >> (4 * d)) == 16'h0);
        sa   = '0;
        ga   = '0;
        if (s < int'(br) && !bv[d] && (!supp || dpv[d])) begin
            sa = 4'b0001 << d;
            ga = {dpv[d], supp ? 7'h00 : HEX[nibv]};
        end
        return {~sa, ~ga};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e        <= 0;
            m_dig    <= '0;
            m_dp     <= '0;
            m_blank  <= '0;
            m_lz     <= 1'b0;
            m_bri    <= '0;
            exp_tick <= 1'b0;
            exp_sel  <= 4'hF;
            exp_seg  <= 8'hFF;
        end else begin
            e        <= e + 1;
            exp_tick <= (e % FRAME == 0);
            if (e >= 1) {exp_sel, exp_seg} <= model_out((e - 1) % FRAME, m_dig, m_dp, m_blank, m_lz, m_bri);
            else        {exp_sel, exp_seg} <= {4'hF, 8'hFF};
            if (e % FRAME == 0) begin
                m_dig   <= digits;
                m_dp    <= dp;
                m_blank <= blank;
                m_lz    <= lz;
                m_bri   <= bri;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_tick", {7'b0, frame_tick}, {7'b0, exp_tick});
            chk("model_sel", {4'b0, sel}, {4'b0, exp_sel});
            chk("model_seg", seg, exp_seg);
        end
    end

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        chk("tick_wait", {7'b0, seen}, 8'd1);
    endtask

    task automatic lit_chk(input string name, input logic [7:0] s, input logic [3:0] d);
        chk({name, "_seg"}, seg, s);
        chk({name, "_sel"}, {4'b0, sel}, {4'b0, d});
    endtask

    initial begin
        int cnt;
        // 1: async reset without a clock
        #2 rst = 1'b1;
        #1;
        lit_chk("rst_noclk", 8'hFF, 4'hF);
        chk("rst_tick", {7'b0, frame_tick}, 8'd0);
        cmp_on = 1'b1;
        digits = 16'h1234; bri = 2'd3;
        #5 rst = 1'b0; run = 1'b1;
        @(negedge clk);
        chk("tick_first", {7'b0, frame_tick}, 8'd1);
        // 2: basic scan of 1234
        skip(1); lit_chk("d0_lit", 8'h99, 4'hE);
        skip(6); lit_chk("d0_dark", 8'hFF, 4'hF);
        skip(2); lit_chk("d1_lit", 8'hB0, 4'hD);
        wait_tick();
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cnt++;
            if (frame_tick === 1'b1) break;
        end
        chk("tick_period", 8'(cnt), 8'd32);

        // 3: leading-zero suppression
        lz = 1'b1; digits = 16'h0070; dp = 4'b1000;
        wait_tick();
        skip(1); lit_chk("lz_d0", 8'hC0, 4'hE);
        skip(8); lit_chk("lz_d1", 8'hF8, 4'hD);
        skip(8); lit_chk("lz_d2", 8'hFF, 4'hF);
        skip(8); lit_chk("lz_d3dp", 8'h7F, 4'h7);
        digits = 16'h0000;
        wait_tick();
        skip(1); lit_chk("lz0_d0", 8'hC0, 4'hE);
        skip(8); lit_chk("lz0_d1", 8'hFF, 4'hF);

        // 4: brightness 0 and 1
        lz = 1'b0; digits = 16'h1234; dp = 4'b0000; bri = 2'd0;
        wait_tick();
        skip(1); lit_chk("bri0", 8'hFF, 4'hF);
        wait_tick();
        bri = 2'd1;
        wait_tick();
        skip(2); lit_chk("bri1_on", 8'h99, 4'hE);
        skip(1); lit_chk("bri1_off", 8'hFF, 4'hF);

        // 5: mid-frame change is deferred to the next frame
        bri = 2'd3;
        wait_tick();
        skip(20);
        digits = 16'hABCD;
        skip(5); lit_chk("shadow_old", 8'hF9, 4'h7);
        wait_tick();
        skip(1); lit_chk("shadow_new", 8'hA1, 4'hE);

        // 6: blank overrides dp; reset mid-dwell
        digits = 16'h1234; blank = 4'b0001; dp = 4'b0001;
        wait_tick();
        skip(1); lit_chk("blank_d0", 8'hFF, 4'hF);
        skip(8); lit_chk("blank_d1", 8'hB0, 4'hD);
        skip(3);
        #2 rst = 1'b1;
        #1 lit_chk("rst_mid", 8'hFF, 4'hF);
        blank = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("tick_after_rst", {7'b0, frame_tick}, 8'd1);
        skip(1); lit_chk("restart_d0", 8'h19, 4'hE);

        // Randomized inputs, changed at arbitrary points in the frame
        for (int n = 0; n < 40; n++) begin
            skip($urandom_range(1, 40));
            digits = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
            dp     = 4'($urandom);
            blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            lz     = 1'($urandom);
            bri    = 2'($urandom);
        end
        skip(2 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seven_seg_scan_n.md
Name: seven_seg_scan_n

Overview:
Parametrised multiplexed seven-segment display driver, generalised from the fixed 4-digit driver to N digits. Adds:
- full hex decode
- per-digit decimal points and blanking
- leading-zero suppression
- PWM brightness control
- frame-synchronous input shadowing, so a frame never shows a mix of old and new values

It sits between the time counter and the board's io_7seg/io_7seg_select pins.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8)
SLOT_CYCLES, 6250, clock cycles per PWM slot (>=1)
BRIGHT_W, 4, brightness width; each digit dwell is 2**BRIGHT_W slots
ACTIVE_LOW, 1, 1 = segment and select outputs are active-low (Cu board), 0 = active-high

Ports:
cu_clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
digits  input  4*DIGITS  hex value per digit; nibble i drives digit i, and digit 0 is rightmost
dp  input  DIGITS  decimal point enable per digit
blank  input  DIGITS  force digit i dark, including its dp
lz_suppress  input  1  enable leading-zero suppression
brightness  input  BRIGHT_W  lit slots per dwell; 0 = off
frame_tick  output  1  one-cycle pulse at each shadow load
io_7seg_select  output  DIGITS  digit enables, one-hot when lit
io_7seg  output  8  bit0..6 = segments a..g, bit7 = dp

Behaviour:
Reset (async assert):
- All counters and shadow registers clear immediately; no clock edge is needed.
- io_7seg and io_7seg_select go inactive: all ones if ACTIVE_LOW, all zeros otherwise. frame_tick = 0.
- A load_pending flag is set.

Scan state:
- prescaler counts 0..SLOT_CYCLES-1.
- slot (BRIGHT_W bits) increments when the prescaler wraps.
- digit index (0..DIGITS-1) increments when slot wraps from 2**BRIGHT_W-1, and wraps from DIGITS-1 to 0.
- Frame length = DIGITS * 2**BRIGHT_W * SLOT_CYCLES cycles.

Shadow load:
- digits, dp, blank, lz_suppress and brightness are copied into shadow registers on either:
  - the first clock edge after reset deasserts (load_pending), or
  - the edge where the digit index wraps to 0.
- frame_tick is registered and is high for exactly the one cycle following each load edge.
- Input changes at any other time have no visible effect until the next load.

Lit condition for the current digit d:
- slot < shadow brightness, AND
- blank[d] = 0, AND
- the digit is not fully suppressed.
- Consequence: brightness = 2**BRIGHT_W-1 still leaves the last slot of each dwell dark. This guarantees at least SLOT_CYCLES dead cycles at every digit change (anti-ghosting).

Leading-zero suppression:
- When lz_suppress = 1, digit d is suppressed if d > 0 and every nibble from DIGITS-1 down to d is 0.
- Digit 0 is never suppressed.
- A suppressed digit still shows its dp if dp[d] = 1; only the segments a..g are dark.
- blank overrides dp.

Hex decode, active-high a..g:
- 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- If ACTIVE_LOW = 1, invert io_7seg and io_7seg_select.

Output timing:
- io_7seg and io_7seg_select are registered with one cycle of latency relative to the scan state and shadow registers.
- When not lit, select is all inactive and segments are all inactive.
- Exactly zero or one select bit is active in any cycle.

Reset mid-frame: outputs go inactive asynchronously, and scanning restarts at digit 0, slot 0 after deassertion.

Test Plan:
Bench parameters for all scenarios: DIGITS=4, SLOT_CYCLES=2, BRIGHT_W=2, ACTIVE_LOW=1; frame length = 32 cycles.
1. Assert reset with no clock running -> io_7seg=FF and io_7seg_select=F immediately. Release reset -> frame_tick pulses once 1 cycle later, then every 32 cycles.
2. digits=0x1234, brightness=3, dp=0, blank=0 ->
   - digit0: select=E, io_7seg=99 (4) for 6 cycles, then 2 dark cycles (select=F).
   - Then digit1 shows B0 (3), digit2 shows A4 (2), digit3 shows F9 (1), each with the same 6 lit / 2 dark pattern.
3. lz_suppress=1, digits=0x0070, dp=1000b ->
   - digit3: only dp lit (io_7seg=7F).
   - digit2: dark.
   - digit1: F8 (7).
   - digit0: C0 (0).
   - With digits=0x0000, only digit0 shows C0.
4. brightness=0 -> select stays F for whole frames; frame_tick continues every 32 cycles. brightness=1 -> each digit lit exactly 2 cycles per 8-cycle dwell.
5. Change digits from 0x1234 to 0xABCD while digit2 is mid-dwell -> remaining digits of that frame still show 1234 patterns; 0xABCD appears starting at the frame_tick; no mixed frame.
6. blank=0001b with dp=0001b -> digit0 fully dark, dp included; other digits unaffected. Assert reset mid-dwell -> outputs inactive asynchronously; after release, scanning resumes at digit0, slot 0.
